// File: rtl/fht_stage_ctrl.sv
// Stage/address sequencer for the radix-2 double-butterfly FHT datapath.
// Optional iHOLD read stall is enabled by defining FHT_STAGE_CTRL_HOLD_EN.
module fht_stage_ctrl #(
  parameter int N_BIT    = 11,
  parameter int STG_BIT  = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iSTART,
`ifdef FHT_STAGE_CTRL_HOLD_EN
  input  logic                iHOLD,
`endif
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oRD_EN,
  output logic [N_BIT-3:0]    oRD_ADDR,
  output logic                oWE,
  output logic [N_BIT-3:0]    oWR_ADDR,
  output logic [N_BIT-3:0]    oW_ADDR,
  output logic [STG_BIT-1:0]  oSTAGE,
  output logic                oST_ZERO,
  output logic [N_BIT-3:0]    oSECTOR,
  output logic                oST_LAST,
  output logic                o2ND_PART_SUBSEC
);

  localparam int ADDR_BIT = N_BIT - 2;
  localparam int DC_BIT   = (PIPE_LAT > 1) ?
                            $clog2(PIPE_LAT) : 1;

  localparam logic [ADDR_BIT-1:0] CNT_MAX = '1;
  localparam logic [ADDR_BIT-1:0] ONE_A =
    ADDR_BIT'(1);
  localparam logic [STG_BIT-1:0] STG_LAST =
    STG_BIT'(N_BIT - 1);
  localparam logic [STG_BIT-1:0] STG_ABIT =
    STG_BIT'(ADDR_BIT);
  localparam logic [STG_BIT-1:0] ONE_S =
    STG_BIT'(1);
  localparam logic [DC_BIT-1:0] DRN_MAX =
    DC_BIT'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                en;
    logic [ADDR_BIT-1:0] addr;
    logic                last;
    logic                half;
  } wr_t;

  state_t              state_q, state_d;
  logic [ADDR_BIT-1:0] rd_cnt_q, rd_cnt_d;
  logic [STG_BIT-1:0]  stage_q, stage_d;
  logic [DC_BIT-1:0]   drn_q, drn_d;

  logic                hold;
  logic                rd_phase;
  logic                rd_c;
  logic                last_c;
  logic                half_c;
  logic [ADDR_BIT-1:0] mask_c;
  logic [ADDR_BIT-1:0] sector_c;
  logic [ADDR_BIT-1:0] waddr_c;
  logic [ADDR_BIT-1:0] half_sh;

  logic                rd_last_q;
  logic                rd_half_q;
  wr_t                 dl_q [PIPE_LAT];

`ifdef FHT_STAGE_CTRL_HOLD_EN
  assign hold = iHOLD;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      stage_q  <= '0;
      drn_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      stage_q  <= stage_d;
      drn_q    <= drn_d;
    end
  end

  // Outputs lag the state by one cycle, so the cycle
  // the host sees oDONE still counts as DONE.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    stage_d  = stage_q;
    drn_d    = drn_q;
    unique case (state_q)
      IDLE: begin
        if (iSTART && !oDONE) begin
          state_d  = READ;
          stage_d  = '0;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        if (!hold) begin
          rd_cnt_d = rd_cnt_q + ONE_A;
          if (rd_cnt_q == CNT_MAX) begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_q == DRN_MAX) begin
          drn_d = '0;
          if (stage_q < STG_LAST) begin
            stage_d = stage_q + ONE_S;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end else begin
          drn_d = drn_q + DC_BIT'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_phase = (state_q == READ);
    rd_c     = rd_phase && !hold;
    last_c   = rd_c && (stage_q == STG_LAST);
    mask_c   = (stage_q >= STG_ABIT) ? '1 :
               ((ONE_A << stage_q) - ONE_A);
    sector_c = rd_phase ? (rd_cnt_q & mask_c) : '0;
    unique case (1'b1)
      (stage_q == '0):
        waddr_c = '0;
      (stage_q >= STG_ABIT):
        waddr_c = sector_c;
      default:
        waddr_c = sector_c << (STG_ABIT - stage_q);
    endcase
    half_sh = rd_cnt_q >> (stage_q - ONE_S);
    half_c  = rd_c && (stage_q != '0) &&
              (stage_q <= STG_ABIT) && half_sh[0];
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
      oRD_EN    <= 1'b0;
      oRD_ADDR  <= '0;
      oW_ADDR   <= '0;
      oSTAGE    <= '0;
      oST_ZERO  <= 1'b0;
      oSECTOR   <= '0;
      rd_last_q <= 1'b0;
      rd_half_q <= 1'b0;
    end else begin
      oBUSY     <= (state_q != IDLE);
      oDONE     <= (state_q == DONE);
      oRD_EN    <= rd_c;
      oRD_ADDR  <= rd_phase ? rd_cnt_q : '0;
      oW_ADDR   <= waddr_c;
      oSTAGE    <= stage_q;
      oST_ZERO  <= rd_phase && (stage_q == '0);
      oSECTOR   <= sector_c;
      rd_last_q <= last_c;
      rd_half_q <= half_c;
    end
  end

  // Write side replays the read issue PIPE_LAT cycles later.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      dl_q[0] <= '{en:   oRD_EN,
                   addr: oRD_ADDR,
                   last: rd_last_q,
                   half: rd_half_q};
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  assign oWE              = dl_q[PIPE_LAT-1].en;
  assign oWR_ADDR         = dl_q[PIPE_LAT-1].addr;
  assign oST_LAST         = dl_q[PIPE_LAT-1].last;
  assign o2ND_PART_SUBSEC = dl_q[PIPE_LAT-1].half;

endmodule

// File: tb/tb_fht_stage_ctrl.sv
// Directed bench for fht_stage_ctrl, N_BIT=4, PIPE_LAT=4.
// Cycle k = k-th rising edge after the one sampling iSTART.
module tb_fht_stage_ctrl;

  localparam int NB = 4;
  localparam int SB = 4;
  localparam int PL = 4;
  localparam int AB = NB - 2;
  localparam int NK = 48;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic          iSTART;
`ifdef FHT_STAGE_CTRL_HOLD_EN
  logic          iHOLD;
`endif
  logic          oBUSY, oDONE, oRD_EN, oWE;
  logic [AB-1:0] oRD_ADDR, oWR_ADDR, oW_ADDR, oSECTOR;
  logic [SB-1:0] oSTAGE;
  logic          oST_ZERO, oST_LAST, o2ND_PART_SUBSEC;

  int checks   = 0;
  int failures = 0;

  logic          t_busy  [NK];
  logic          t_done  [NK];
  logic          t_rd_en [NK];
  logic [AB-1:0] t_rd_a  [NK];
  logic          t_we    [NK];
  logic [AB-1:0] t_wr_a  [NK];
  logic [AB-1:0] t_w_a   [NK];
  logic [SB-1:0] t_stage [NK];
  logic          t_zero  [NK];
  logic [AB-1:0] t_sec   [NK];
  logic          t_last  [NK];
  logic          t_half  [NK];

  logic [AB-1:0] s1_sec  [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
  logic [AB-1:0] s1_wa   [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
  logic          s1_half [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [AB-1:0] s2_sec  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [AB-1:0] s2_wa   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic          s2_half [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  fht_stage_ctrl #(
    .N_BIT    (NB),
    .STG_BIT  (SB),
    .PIPE_LAT (PL)
  ) dut (
    .iCLK             (iCLK),
    .iRESET           (iRESET),
    .iSTART           (iSTART),
`ifdef FHT_STAGE_CTRL_HOLD_EN
    .iHOLD            (iHOLD),
`endif
    .oBUSY            (oBUSY),
    .oDONE            (oDONE),
    .oRD_EN           (oRD_EN),
    .oRD_ADDR         (oRD_ADDR),
    .oWE              (oWE),
    .oWR_ADDR         (oWR_ADDR),
    .oW_ADDR          (oW_ADDR),
    .oSTAGE           (oSTAGE),
    .oST_ZERO         (oST_ZERO),
    .oSECTOR          (oSECTOR),
    .oST_LAST         (oST_LAST),
    .o2ND_PART_SUBSEC (o2ND_PART_SUBSEC)
  );

  always #5 iCLK = ~iCLK;

  task automatic cap(input int k);
    t_busy[k]  = oBUSY;
    t_done[k]  = oDONE;
    t_rd_en[k] = oRD_EN;
    t_rd_a[k]  = oRD_ADDR;
    t_we[k]    = oWE;
    t_wr_a[k]  = oWR_ADDR;
    t_w_a[k]   = oW_ADDR;
    t_stage[k] = oSTAGE;
    t_zero[k]  = oST_ZERO;
    t_sec[k]   = oSECTOR;
    t_last[k]  = oST_LAST;
    t_half[k]  = o2ND_PART_SUBSEC;
  endtask

  task automatic do_run();
    @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    cap(0);
    for (int k = 1; k < NK; k++) begin
      @(negedge iCLK);
      cap(k);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    iRESET = 1'b0;
    iSTART = 1'b0;
`ifdef FHT_STAGE_CTRL_HOLD_EN
    iHOLD  = 1'b0;
`endif
    repeat (3) @(negedge iCLK);
    v = {oBUSY, oDONE, oRD_EN, oRD_ADDR, oWE,
         oWR_ADDR, oW_ADDR, oSTAGE, oST_ZERO,
         oSECTOR, oST_LAST, o2ND_PART_SUBSEC};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", v);
    end
    iRESET = 1'b1;
    repeat (2) @(negedge iCLK);
    checks++;
    if ({oBUSY, oDONE, oRD_EN} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000",
               {oBUSY, oDONE, oRD_EN});
    end
  endtask

  task automatic test_read_seq();
    logic          e_en;
    logic [AB-1:0] e_a;
    do_run();
    for (int k = 1; k <= 32; k++) begin
      e_en = ((k - 1) % 8) < 4;
      e_a  = e_en ? AB'((k - 1) % 8) : '0;
      checks++;
      if (t_rd_en[k] !== e_en || t_rd_a[k] !== e_a) begin
        failures++;
        $display("FAIL rd_seq k=%0d got=%b/%0d exp=%b/%0d",
                 k, t_rd_en[k], t_rd_a[k], e_en, e_a);
      end
      checks++;
      if (t_rd_en[k] && t_stage[k] !== SB'((k - 1) / 8)) begin
        failures++;
        $display("FAIL rd_stage k=%0d got=%0d exp=%0d",
                 k, t_stage[k], (k - 1) / 8);
      end
    end
    for (int k = 0; k < NK; k++) begin
      checks++;
      if (t_done[k] !== (k == 33)) begin
        failures++;
        $display("FAIL done k=%0d got=%b exp=%b",
                 k, t_done[k], k == 33);
      end
      checks++;
      if (t_busy[k] !== (k >= 1 && k <= 33)) begin
        failures++;
        $display("FAIL busy k=%0d got=%b exp=%b",
                 k, t_busy[k], k >= 1 && k <= 33);
      end
    end
  endtask

  task automatic test_write_side();
    logic          e_we, e_last;
    logic [AB-1:0] e_a;
    do_run();
    for (int k = 0; k < 42; k++) begin
      e_we   = k >= 5 && k <= 36 && ((k - 5) % 8) < 4;
      e_a    = e_we ? AB'((k - 5) % 8) : '0;
      e_last = e_we && ((k - 5) / 8) == 3;
      checks++;
      if (t_we[k] !== e_we || t_wr_a[k] !== e_a ||
          t_last[k] !== e_last) begin
        failures++;
        $display("FAIL wr_side k=%0d got=%b/%0d/%b exp=%b/%0d/%b",
                 k, t_we[k], t_wr_a[k], t_last[k],
                 e_we, e_a, e_last);
      end
    end
  endtask

  task automatic test_stage_fields();
    do_run();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (t_zero[1+i] !== 1'b1 || t_sec[1+i] !== '0 ||
          t_w_a[1+i] !== '0) begin
        failures++;
        $display("FAIL st0_fields i=%0d got=%b/%0d/%0d exp=1/0/0",
                 i, t_zero[1+i], t_sec[1+i], t_w_a[1+i]);
      end
      checks++;
      if (t_zero[9+i] !== 1'b0 || t_sec[9+i] !== s1_sec[i] ||
          t_w_a[9+i] !== s1_wa[i]) begin
        failures++;
        $display("FAIL st1_fields i=%0d got=%b/%0d/%0d exp=0/%0d/%0d",
                 i, t_zero[9+i], t_sec[9+i], t_w_a[9+i],
                 s1_sec[i], s1_wa[i]);
      end
      checks++;
      if (t_half[13+i] !== s1_half[i]) begin
        failures++;
        $display("FAIL st1_half i=%0d got=%b exp=%b",
                 i, t_half[13+i], s1_half[i]);
      end
      checks++;
      if (t_zero[17+i] !== 1'b0 || t_sec[17+i] !== s2_sec[i] ||
          t_w_a[17+i] !== s2_wa[i]) begin
        failures++;
        $display("FAIL st2_fields i=%0d got=%b/%0d/%0d exp=0/%0d/%0d",
                 i, t_zero[17+i], t_sec[17+i], t_w_a[17+i],
                 s2_sec[i], s2_wa[i]);
      end
      checks++;
      if (t_half[21+i] !== s2_half[i]) begin
        failures++;
        $display("FAIL st2_half i=%0d got=%b exp=%b",
                 i, t_half[21+i], s2_half[i]);
      end
      checks++;
      if (t_sec[25+i] !== AB'(i) || t_half[29+i] !== 1'b0) begin
        failures++;
        $display("FAIL st3_fields i=%0d got=%0d/%b exp=%0d/0",
                 i, t_sec[25+i], t_half[29+i], i);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    int k_done = -1;
    int late   = 0;
    @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    for (int k = 1; k < 56; k++) begin
      @(negedge iCLK);
      if (oDONE) begin
        n_done++;
        k_done = k;
      end
      if (k > 34 && (oRD_EN || oBUSY)) late++;
      iSTART = (k == 10) || oDONE;
    end
    iSTART = 1'b0;
    checks++;
    if (n_done !== 1 || k_done !== 33) begin
      failures++;
      $display("FAIL start_ignored done n=%0d k=%0d exp n=1 k=33",
               n_done, k_done);
    end
    checks++;
    if (late !== 0) begin
      failures++;
      $display("FAIL start_ignored restart cycles=%0d exp=0", late);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int          n_done;
    @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    repeat (22) @(negedge iCLK);
    checks++;
    if (oWE !== 1'b1 || oRD_EN !== 1'b0) begin
      failures++;
      $display("FAIL mid_drain we/rd got=%b/%b exp=1/0",
               oWE, oRD_EN);
    end
    #1 iRESET = 1'b0;
    #1;
    v = {oBUSY, oDONE, oRD_EN, oRD_ADDR, oWE,
         oWR_ADDR, oW_ADDR, oSTAGE, oST_ZERO,
         oSECTOR, oST_LAST, o2ND_PART_SUBSEC};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL async_abort got=%h exp=0", v);
    end
    @(negedge iCLK);
    iRESET = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge iCLK);
      if (oDONE || oBUSY || oWE) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL abort_quiet active_cycles=%0d exp=0", n_done);
    end
    do_run();
    checks++;
    if (t_stage[1] !== '0 || t_zero[1] !== 1'b1 ||
        t_rd_a[2] !== 2'd1) begin
      failures++;
      $display("FAIL restart_stage0 got=%0d/%b/%0d exp=0/1/1",
               t_stage[1], t_zero[1], t_rd_a[2]);
    end
    checks++;
    if (t_done[33] !== 1'b1 || t_done[32] !== 1'b0) begin
      failures++;
      $display("FAIL restart_done got=%b%b exp=01",
               t_done[32], t_done[33]);
    end
  endtask

`ifdef FHT_STAGE_CTRL_HOLD_EN
  task automatic test_hold();
    logic [AB-1:0] e_a  [8] = '{2'd0, 2'd0, 2'd1, 2'd2,
                                2'd2, 2'd2, 2'd2, 2'd3};
    logic          e_en [8] = '{1'b0, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b1};
    logic          e_we [8] = '{1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge iCLK);
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    cap(0);
    for (int k = 1; k < NK; k++) begin
      @(negedge iCLK);
      cap(k);
      iHOLD = (k >= 2 && k <= 4);
    end
    iHOLD = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (t_rd_en[k] !== e_en[k] || t_rd_a[k] !== e_a[k]) begin
        failures++;
        $display("FAIL hold_rd k=%0d got=%b/%0d exp=%b/%0d",
                 k, t_rd_en[k], t_rd_a[k], e_en[k], e_a[k]);
      end
      checks++;
      if (t_we[5+k] !== e_we[k]) begin
        failures++;
        $display("FAIL hold_we k=%0d got=%b exp=%b",
                 5 + k, t_we[5+k], e_we[k]);
      end
    end
    checks++;
    if (t_done[36] !== 1'b1 || t_done[33] !== 1'b0) begin
      failures++;
      $display("FAIL hold_done got=%b%b exp=01",
               t_done[33], t_done[36]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_seq();
    test_write_side();
    test_stage_fields();
    test_start_ignored();
    test_reset_mid();
`ifdef FHT_STAGE_CTRL_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
